// File: rtl/bist_controller.sv
// BIST session sequencer: INIT -> N x (SHIFT, CAPTURE) -> UNLOAD -> COMPARE -> DONE, with registered strobes.
// Optional macro BIST_ABORT_EN: dropping bist_start mid-session returns to IDLE without a result.
module bist_controller #(
  parameter int               N_PATTERNS = 4,
  parameter int               SCAN_LEN   = 3,
  parameter int               SIG_W      = 16,
  parameter logic [SIG_W-1:0] GOLDEN_SIG = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bist_start,
  input  logic [SIG_W-1:0] signature,
  output logic             test_mode,
  output logic             scan_en,
  output logic             cut_reset,
  output logic             lfsr_init,
  output logic             lfsr_en,
  output logic             misr_init,
  output logic             misr_en,
  output logic             bist_end,
  output logic             pass_nfail
);

  localparam int PW = $clog2(N_PATTERNS) + 1;
  localparam int SW = $clog2(SCAN_LEN) + 1;
  localparam logic [PW-1:0] PAT_END = PW'(N_PATTERNS);
  localparam logic [SW-1:0] SH_LAST = SW'(SCAN_LEN - 1);

  typedef enum logic [2:0] {IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pat_cnt, pat_nxt;
  logic [SW-1:0] sh_cnt, sh_nxt;
  logic          test_mode_nxt, scan_en_nxt, cut_reset_nxt, lfsr_init_nxt, lfsr_en_nxt;
  logic          misr_init_nxt, misr_en_nxt, bist_end_nxt, pass_nfail_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      pat_cnt    <= '0;
      sh_cnt     <= '0;
      test_mode  <= 1'b0;
      scan_en    <= 1'b0;
      cut_reset  <= 1'b0;
      lfsr_init  <= 1'b0;
      lfsr_en    <= 1'b0;
      misr_init  <= 1'b0;
      misr_en    <= 1'b0;
      bist_end   <= 1'b0;
      pass_nfail <= 1'b0;
    end else begin
      state      <= state_nxt;
      pat_cnt    <= pat_nxt;
      sh_cnt     <= sh_nxt;
      test_mode  <= test_mode_nxt;
      scan_en    <= scan_en_nxt;
      cut_reset  <= cut_reset_nxt;
      lfsr_init  <= lfsr_init_nxt;
      lfsr_en    <= lfsr_en_nxt;
      misr_init  <= misr_init_nxt;
      misr_en    <= misr_en_nxt;
      bist_end   <= bist_end_nxt;
      pass_nfail <= pass_nfail_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pat_nxt        = pat_cnt;
    sh_nxt         = sh_cnt;
    test_mode_nxt  = 1'b0;
    scan_en_nxt    = 1'b0;
    cut_reset_nxt  = 1'b0;
    lfsr_init_nxt  = 1'b0;
    lfsr_en_nxt    = 1'b0;
    misr_init_nxt  = 1'b0;
    misr_en_nxt    = 1'b0;
    bist_end_nxt   = 1'b0;
    pass_nfail_nxt = 1'b0;

    case (state)
      IDLE:    if (bist_start) state_nxt = INIT;
      INIT: begin
        state_nxt = SHIFT;
        pat_nxt   = '0;
        sh_nxt    = '0;
      end
      SHIFT, UNLOAD: begin
        if (sh_cnt == SH_LAST) begin
          sh_nxt    = '0;
          state_nxt = (state == SHIFT) ? CAPTURE : COMPARE;
        end else begin
          sh_nxt = sh_cnt + SW'(1);
        end
      end
      CAPTURE: begin
        pat_nxt   = pat_cnt + PW'(1);
        sh_nxt    = '0;
        state_nxt = (pat_nxt == PAT_END) ? UNLOAD : SHIFT;
      end
      COMPARE: state_nxt = DONE;
      DONE:    if (!bist_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

`ifdef BIST_ABORT_EN
    if (!bist_start && state != IDLE && state != DONE) state_nxt = IDLE;
`endif

    // Outputs are decoded from the upcoming state so they appear registered with it.
    case (state_nxt)
      INIT: begin
        test_mode_nxt = 1'b1;
        cut_reset_nxt = 1'b1;
        lfsr_init_nxt = 1'b1;
        misr_init_nxt = 1'b1;
      end
      SHIFT: begin
        test_mode_nxt = 1'b1;
        scan_en_nxt   = 1'b1;
        lfsr_en_nxt   = 1'b1;
        misr_en_nxt   = (pat_nxt != '0);
      end
      CAPTURE: test_mode_nxt = 1'b1;
      UNLOAD: begin
        test_mode_nxt = 1'b1;
        scan_en_nxt   = 1'b1;
        misr_en_nxt   = 1'b1;
      end
      DONE: begin
        bist_end_nxt   = 1'b1;
        pass_nfail_nxt = (state == COMPARE) ? (signature == GOLDEN_SIG) : pass_nfail;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bist_controller.sv
// Self-checking bench for bist_controller: per-cycle waveform checked against a timing-formula model.
module tb_bist_controller;
  localparam int N = 4;
  localparam int L = 3;
  localparam int W = 16;
  localparam logic [W-1:0] GOLD = 16'hA5C3;
  localparam int T = 2 + N * (L + 1) + L;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         bist_start = 1'b0;
  logic [W-1:0] signature = '0;
  logic test_mode, scan_en, cut_reset, lfsr_init, lfsr_en, misr_init, misr_en, bist_end, pass_nfail;
  logic [8:0] outv;

  int total = 0;
  int bad = 0;

  bist_controller #(.N_PATTERNS(N), .SCAN_LEN(L), .SIG_W(W), .GOLDEN_SIG(GOLD)) dut (
    .clock(clock), .reset(reset), .bist_start(bist_start), .signature(signature),
    .test_mode(test_mode), .scan_en(scan_en), .cut_reset(cut_reset), .lfsr_init(lfsr_init),
    .lfsr_en(lfsr_en), .misr_init(misr_init), .misr_en(misr_en), .bist_end(bist_end),
    .pass_nfail(pass_nfail)
  );

  always #5 clock = ~clock;

  // bit order: test_mode scan_en cut_reset lfsr_init lfsr_en misr_init misr_en bist_end pass_nfail
  assign outv = {test_mode, scan_en, cut_reset, lfsr_init, lfsr_en, misr_init, misr_en, bist_end, pass_nfail};

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected outputs t edges after the edge that sampled bist_start in IDLE.
  function automatic logic [8:0] model(int t, bit pass, int hold, bit aborted, int drop_at);
    logic [8:0] e;
    int j, k;
    e = '0;
    if (aborted && t > drop_at) return e;
    if (t == 0) begin
      e[8] = 1'b1; e[6] = 1'b1; e[5] = 1'b1; e[3] = 1'b1;
    end else if (t <= N * (L + 1)) begin
      j = (t - 1) % (L + 1);
      k = (t - 1) / (L + 1);
      e[8] = 1'b1;
      if (j < L) begin
        e[7] = 1'b1; e[4] = 1'b1; e[2] = (k != 0);
      end
    end else if (t <= N * (L + 1) + L) begin
      e[8] = 1'b1; e[7] = 1'b1; e[2] = 1'b1;
    end else if (t >= T && t < T + hold) begin
      e[1] = 1'b1; e[0] = pass;
    end
    return e;
  endfunction

  // One session; hold = cycles bist_end stays up with start held, drop_early >= 0 drops start after that t.
  task automatic run_session(input logic [W-1:0] cmp_sig, input int hold, input int drop_early, input string name);
    int drop_at, hold_eff, first_end, lfsr_cnt, misr_cnt, scan_low, cut_cnt;
    bit pass, aborted, pn_end;
    logic [8:0] e;
    pass      = (cmp_sig == GOLD);
    drop_at   = (drop_early >= 0) ? drop_early : T + hold - 1;
    hold_eff  = (drop_at >= T) ? drop_at - T + 1 : 1;
    aborted   = 1'b0;
`ifdef BIST_ABORT_EN
    aborted   = (drop_at <= T - 1);
`endif
    first_end = -1; lfsr_cnt = 0; misr_cnt = 0; scan_low = 0; cut_cnt = 0; pn_end = 1'b0;
    bist_start = 1'b1;
    signature  = W'($urandom);
    for (int t = 0; t <= T + hold_eff + 3; t++) begin
      tick();
      e = model(t, pass, hold_eff, aborted, drop_at);
      total++;
      if (outv !== e) begin
        bad++;
        $display("FAIL %s wave t=%0d got=%b want=%b", name, t, outv, e);
      end
      if (lfsr_en === 1'b1) lfsr_cnt++;
      if (misr_en === 1'b1) misr_cnt++;
      if (cut_reset === 1'b1) cut_cnt++;
      if (t >= 1 && t <= N * (L + 1) + L && scan_en === 1'b0) scan_low++;
      if (bist_end === 1'b1 && first_end < 0) begin
        first_end = t;
        pn_end = pass_nfail;
      end
      if (t == drop_at) bist_start = 1'b0;
      signature = (t == T - 1) ? cmp_sig : W'($urandom);
    end
    total++;
    if (first_end !== (aborted ? -1 : T)) begin
      bad++;
      $display("FAIL %s end_edge got=%0d want=%0d", name, first_end, aborted ? -1 : T);
    end
    if (!aborted) begin
      total++;
      if (pn_end !== pass) begin
        bad++;
        $display("FAIL %s pass_nfail got=%b want=%b", name, pn_end, pass);
      end
      total++;
      if (lfsr_cnt !== N * L) begin
        bad++;
        $display("FAIL %s lfsr_count got=%0d want=%0d", name, lfsr_cnt, N * L);
      end
      total++;
      if (misr_cnt !== N * L) begin
        bad++;
        $display("FAIL %s misr_count got=%0d want=%0d", name, misr_cnt, N * L);
      end
      total++;
      if (scan_low !== N || cut_cnt !== 1) begin
        bad++;
        $display("FAIL %s strobe_counts scan_low=%0d cut=%0d want %0d 1", name, scan_low, cut_cnt, N);
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (outv !== 9'b0) begin
        bad++;
        $display("FAIL reset_hold got=%b want=%b", outv, 9'b0);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (outv !== 9'b0) begin
        bad++;
        $display("FAIL reset_idle got=%b want=%b", outv, 9'b0);
      end
    end
  endtask

  task automatic test_pass();
    run_session(GOLD, 1, -1, "pass");
  endtask

  task automatic test_fail();
    run_session(GOLD ^ 16'h0001, 1, -1, "fail");
  endtask

  task automatic test_back_to_back();
    run_session(GOLD, 10, -1, "handshake1");
    run_session(GOLD, 10, -1, "handshake2");
  endtask

  task automatic test_reset_mid();
    logic [8:0] e;
    bist_start = 1'b1;
    for (int t = 0; t <= 10; t++) begin
      tick();
      e = model(t, 1'b1, 1, 1'b0, 0);
      total++;
      if (outv !== e) begin
        bad++;
        $display("FAIL reset_mid wave t=%0d got=%b want=%b", t, outv, e);
      end
    end
    reset = 1'b1;
    bist_start = 1'b0;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      total++;
      if (outv !== 9'b0) begin
        bad++;
        $display("FAIL reset_mid_quiet i=%0d got=%b want=%b", i, outv, 9'b0);
      end
      tick();
    end
    run_session(GOLD, 2, -1, "after_reset");
  endtask

  task automatic test_abort();
    run_session(GOLD, 1, 7, "abort");
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] s;
    int h;
    for (int i = 0; i < 6; i++) begin
      s = ($urandom_range(0, 1) == 1) ? GOLD : GOLD ^ W'($urandom_range(1, 65535));
      h = $urandom_range(1, 5);
      run_session(s, h, -1, "random");
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) tick();
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail();
    test_back_to_back();
    test_reset_mid();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bist_controller.md
# bist_controller

Sequencing FSM of the BIST wrapper inside `top_level`, directly upstream of the LFSR pattern generator, the scan-chain CUT and the MISR compactor. It runs a test session on `bist_start` and drives the LFSR/MISR/scan control strobes. At the end it compares the MISR signature with a golden value. It produces the `bist_end` and `pass_nfail` outputs that the chip-level bench observes.

## Interface
- `N_PATTERNS`, default 4: number of scan patterns applied per session (≥1).
- `SCAN_LEN`, default 3: scan chain length in flip-flops (≥1).
- `SIG_W`, default 16: MISR signature width.
- `GOLDEN_SIG`, default 16'h0000: expected fault-free signature, SIG_W bits.
- `clock`, input, 1: system clock; all logic updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `bist_start`, input, 1: session request, level-sampled in IDLE.
- `signature`, input, SIG_W: current MISR contents.
- `test_mode`, output, 1: CUT input mux select (1 = LFSR drives CUT).
- `scan_en`, output, 1: scan shift enable (0 = functional capture).
- `cut_reset`, output, 1: CUT reset strobe.
- `lfsr_init`, output, 1: load LFSR seed.
- `lfsr_en`, output, 1: advance LFSR.
- `misr_init`, output, 1: clear MISR to its seed.
- `misr_en`, output, 1: compact scan-out into MISR.
- `bist_end`, output, 1: session complete.
- `pass_nfail`, output, 1: 1 = signature matched GOLDEN_SIG. Valid only while `bist_end`=1.

## Operation
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE, DONE. The state register and all outputs are registered.
- Reset: state goes to IDLE and counters are cleared. Every output is 0.
- IDLE: all outputs 0. If `bist_start`=1 at an edge, go to INIT.
- INIT (1 cycle): `test_mode`=1, `cut_reset`=1, `lfsr_init`=1, `misr_init`=1. Next state is SHIFT, and the pattern counter is cleared to 0.
- SHIFT (SCAN_LEN cycles): `test_mode`=1, `scan_en`=1, `lfsr_en`=1.
  - `misr_en`=1 unless pattern counter = 0, because the first unload only carries reset state.
  - The shift counter counts 0..SCAN_LEN-1, then the FSM goes to CAPTURE.
- CAPTURE (1 cycle): `test_mode`=1, `scan_en`=0, `lfsr_en`=0, `misr_en`=0. The pattern counter increments.
  - If the incremented count equals N_PATTERNS, go to UNLOAD. Otherwise go back to SHIFT.
- UNLOAD (SCAN_LEN cycles): `test_mode`=1, `scan_en`=1, `misr_en`=1, `lfsr_en`=0. Then go to COMPARE.
- COMPARE (1 cycle): all strobes 0.
  - `pass_nfail` is loaded with (`signature` == GOLDEN_SIG), using the full SIG_W-bit equality.
  - Next state is DONE.
- DONE: `bist_end`=1, and `pass_nfail` holds its value.
  - The FSM stays in DONE while `bist_start`=1.
  - When `bist_start`=0 it returns to IDLE. On that transition `bist_end` and `pass_nfail` clear to 0.
- `bist_start` toggling during INIT..COMPARE is ignored. See `BIST_ABORT_EN` for the exception.
- Counter widths are $clog2 of the terminal value plus 1. No wrap-around is reachable.
- `reset` asserted in any state overrides everything. It forces IDLE at that edge, even in the middle of a session or in DONE.

## Timing
- Let edge 0 be the edge at which IDLE samples `bist_start`=1, and let L = SCAN_LEN, N = N_PATTERNS.
- INIT is active after edge 0. SHIFT for pattern k (k = 0..N-1) starts after edge 1+k(L+1).
- UNLOAD starts after edge 1+N(L+1). COMPARE starts after edge 1+N(L+1)+L.
- `bist_end` rises after edge T = 2+N(L+1)+L. `pass_nfail` becomes valid in the same cycle.
- With the defaults (N=4, L=3), T = 21.
- Total `lfsr_en` cycles = N·L. Total `misr_en` cycles = N·L; this is (N-1)·L in SHIFT plus L in UNLOAD.
- DONE→IDLE occurs at the first edge with `bist_start`=0. A new session needs `bist_start` to be seen high again in IDLE, so there are at least 2 edges between sessions.

## Configuration
- `BIST_ABORT_EN` defined: in states INIT..COMPARE, `bist_start`=0 at an edge forces IDLE. All outputs go to 0, and neither `bist_end` nor `pass_nfail` is asserted.
- `BIST_ABORT_EN` undefined: `bist_start` is a don't-care outside IDLE and DONE, and a session always runs to completion.

## Test plan
- Reset then pass: release `reset` and hold `bist_start`=1 from cycle 5, with `signature` = GOLDEN_SIG. Required: `bist_end` rises exactly 21 edges after the sampling edge, `pass_nfail`=1, and exactly 12 `lfsr_en` and 12 `misr_en` cycles occur.
- Fail: same as the pass scenario, but `signature` = GOLDEN_SIG ^ 16'h0001 during COMPARE. Required: `bist_end`=1 with `pass_nfail`=0.
- Handshake: hold `bist_start`=1 for 10 cycles after `bist_end` rises, then drop it. Required: `bist_end` and `pass_nfail` are held for those 10 cycles and clear 1 edge after the drop. A second session produces an identical waveform.
- Reset mid-run: assert `reset` for 1 cycle during SHIFT of pattern 2. Required: all outputs are 0 on the next cycle, the FSM is in IDLE, and no `bist_end` appears unless `bist_start` is sampled again.
- Strobe ordering: at INIT, `cut_reset`, `lfsr_init` and `misr_init` are each high for exactly 1 cycle. `scan_en` is low for exactly the 4 single CAPTURE cycles between shift bursts. `misr_en` is 0 throughout pattern 0.
- With `BIST_ABORT_EN`: drop `bist_start` at cycle 8 of a session. Required: IDLE on the next edge and `bist_end` never asserts. Without the macro, the same stimulus still gives `bist_end` at edge 21.
